// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, counter debounce, and registered
// level / press / release / auto-repeat pulses for a single raw button pad.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 650_000,
   parameter int REPEAT_DELAY    = 26_000_000,
   parameter int REPEAT_PERIOD   = 6_500_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release,
   output logic btn_repeat,
   output logic btn_evt
);

   localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
   localparam int MAX_P  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
   localparam int CW     = $clog2(MAX_P);

   // The edge that first sees btn_sync change already counts as one stable cycle,
   // so a debounce window ends one count early to give DEBOUNCE_CYCLES+2 latency.
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 2);
   localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

   typedef enum logic [2:0] {
      IDLE,
      DB_PRESS,
      HELD,
      REPEAT,
      DB_RELEASE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sync1_q, btn_sync_q;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic          repeat_q, repeat_d;
   logic          evt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q    <= 1'b0;
         btn_sync_q <= 1'b0;
         state_q    <= IDLE;
         cnt_q      <= '0;
         level_q    <= 1'b0;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         repeat_q   <= 1'b0;
         evt_q      <= 1'b0;
      end else begin
         sync1_q    <= btn_in;
         btn_sync_q <= sync1_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         level_q    <= level_d;
         press_q    <= press_d;
         release_q  <= release_d;
         repeat_q   <= repeat_d;
         evt_q      <= press_d | repeat_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 1'b1;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      repeat_d  = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (btn_sync_q) state_d = DB_PRESS;
         end
         DB_PRESS: begin
            if (!btn_sync_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d = HELD;
               cnt_d   = '0;
               level_d = 1'b1;
               press_d = 1'b1;
            end
         end
         HELD: begin
            if (!btn_sync_q) begin
               state_d = DB_RELEASE;
               cnt_d   = '0;
            end else if (cnt_q == RD_LAST) begin
               state_d  = REPEAT;
               cnt_d    = '0;
               repeat_d = 1'b1;
            end
         end
         REPEAT: begin
            if (!btn_sync_q) begin
               state_d = DB_RELEASE;
               cnt_d   = '0;
            end else if (cnt_q == RP_LAST) begin
               cnt_d    = '0;
               repeat_d = 1'b1;
            end
         end
         DB_RELEASE: begin
            // A bounce back to 1 restarts the full repeat delay without a new press.
            if (btn_sync_q) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d   = IDLE;
               cnt_d     = '0;
               level_d   = 1'b0;
               release_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;
   assign btn_repeat  = repeat_q;
   assign btn_evt     = evt_q;

endmodule
